control_sequencer: RTL and testbench

Hardwired Mini SRC control unit that sits directly upstream of DataPath and drives every bus-select, register-enable, ALU and memory-control input that DataPath takes.
- Fetch: runs a T0..T2 fetch, waiting on a memory-ready handshake.
- Decode/execute: decodes the IR image returned by DataPath and sequences T3..T6 execute steps for ALU instructions.
- Replaces bench-driven state sequencing with synthesizable logic.

---
 rtl/control_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_control_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer
//  Description : Hardwired Mini SRC control unit. Runs the T0..T2 fetch with a
//                memory-ready handshake, latches the IR fields and sequences
//                the T3..T6 execute steps for ALU instructions, driving every
//                DataPath select/enable. Optional single-step mode is enabled
//                by defining CTRL_SINGLE_STEP_EN (adds the w_step input).
//  Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer #(
  parameter int NREGS = 16,
  parameter int OPW   = 6
) (
  input  logic             w_clock,
  input  logic             w_clear,
  input  logic             w_run,
  input  logic             w_mem_rdy,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic             w_step,
`endif
  input  logic [31:0]      ir,
  output logic             s_PC,
  output logic             s_Zlow,
  output logic             s_Zhigh,
  output logic             s_MDR,
  output logic             s_HI,
  output logic             s_LO,
  output logic             e_MAR,
  output logic             e_Z,
  output logic             e_PC,
  output logic             e_MDR,
  output logic             e_IR,
  output logic             e_Y,
  output logic             e_HI,
  output logic             e_LO,
  output logic             w_IncPC,
  output logic             w_read,
  output logic             e_alu,
  output logic [OPW-1:0]   opcode,
  output logic [NREGS-1:0] s_R,
  output logic [NREGS-1:0] e_R,
  output logic             halted
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  localparam logic [NREGS-1:0] ONE_HOT_BASE = NREGS'(1);
  localparam logic [4:0]       OP_NOT  = 5'd4;
  localparam logic [4:0]       OP_MUL  = 5'd5;
  localparam logic [4:0]       OP_DIV  = 5'd6;
  localparam logic [4:0]       OP_NEG  = 5'd12;
  localparam logic [4:0]       OP_HALT = 5'd31;

  state_t     state_q, state_d;
  logic [4:0] op_q, op_d;
  logic [3:0] ra_q, ra_d;
  logic [3:0] rb_q, rb_d;
  logic [3:0] rc_q, rc_d;
  logic       t1_seen_q, t1_seen_d;   // set after the first T1 cycle so PC loads once
  logic       step_q, step_d;         // previous w_step level for edge detection

  logic is_alu, is_unary, is_muldiv;
  logic start_fetch;
  state_t done_state;

  // Low IR bits carry immediates this unit does not decode.
  logic unused_bits;
`ifdef CTRL_SINGLE_STEP_EN
  assign unused_bits = ^{ir[14:0], w_run};
`else
  assign unused_bits = ^ir[14:0];
`endif

  // State register and latched IR fields; cleared asynchronously.
  always_ff @(posedge w_clock or negedge w_clear) begin
    if (!w_clear) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      rc_q      <= '0;
      t1_seen_q <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      rc_q      <= rc_d;
      t1_seen_q <= t1_seen_d;
      step_q    <= step_d;
    end
  end

  // Next-state, field capture and Moore output decode.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    rc_d      = rc_q;
    t1_seen_d = 1'b0;
    s_PC = 1'b0;  s_Zlow = 1'b0; s_Zhigh = 1'b0; s_MDR = 1'b0;
    s_HI = 1'b0;  s_LO   = 1'b0;
    e_MAR = 1'b0; e_Z = 1'b0; e_PC = 1'b0; e_MDR = 1'b0;
    e_IR  = 1'b0; e_Y = 1'b0; e_HI = 1'b0; e_LO  = 1'b0;
    w_IncPC = 1'b0; w_read = 1'b0; e_alu = 1'b0;
    opcode  = '0;
    s_R     = '0;
    e_R     = '0;
    halted  = 1'b0;

    // Opcodes 0..12 are real ALU operations; everything else but halt is a nop.
    is_alu    = (op_q <= OP_NEG);
    is_unary  = (op_q == OP_NOT) || (op_q == OP_NEG);
    is_muldiv = (op_q == OP_MUL) || (op_q == OP_DIV);

`ifdef CTRL_SINGLE_STEP_EN
    step_d      = w_step;
    start_fetch = w_step && !step_q;
    done_state  = S_IDLE;
`else
    step_d      = 1'b0;
    start_fetch = w_run;
    done_state  = w_run ? S_T0 : S_IDLE;
`endif

    case (state_q)
      S_IDLE: begin
        if (start_fetch) state_d = S_T0;
      end
      S_T0: begin
        s_PC = 1'b1; e_MAR = 1'b1; w_IncPC = 1'b1; e_Z = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        s_Zlow = 1'b1; w_read = 1'b1; e_MDR = 1'b1;
        e_PC      = !t1_seen_q;
        t1_seen_d = 1'b1;
        if (w_mem_rdy) state_d = S_T2;
      end
      S_T2: begin
        s_MDR = 1'b1; e_IR = 1'b1;
        op_d = ir[31:27];
        ra_d = ir[26:23];
        rb_d = ir[22:19];
        rc_d = ir[18:15];
        state_d = S_T3;
      end
      S_T3: begin
        if (op_q == OP_HALT) begin
          state_d = S_HALT;
        end else if (is_alu) begin
          s_R = ONE_HOT_BASE << rb_q;
          e_Y = 1'b1;
          state_d = S_T4;
        end else begin
          state_d = done_state;
        end
      end
      S_T4: begin
        s_R    = ONE_HOT_BASE << (is_unary ? rb_q : rc_q);
        e_alu  = 1'b1;
        e_Z    = 1'b1;
        opcode = OPW'(op_q);
        state_d = S_T5;
      end
      S_T5: begin
        s_Zlow = 1'b1;
        if (is_muldiv) begin
          e_LO    = 1'b1;
          state_d = S_T6;
        end else begin
          e_R     = ONE_HOT_BASE << ra_q;
          state_d = done_state;
        end
      end
      S_T6: begin
        s_Zhigh = 1'b1; e_HI = 1'b1;
        state_d = done_state;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_sequencer
//  Description : Self-checking bench for control_sequencer. An instruction-
//                level model expands each instruction into its expected
//                per-cycle control bundles; a compare process checks every
//                cycle, and literal checks pin selected cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

  typedef struct packed {
    logic s_pc, s_zlow, s_zhigh, s_mdr, s_hi, s_lo;
    logic e_mar, e_z, e_pc, e_mdr, e_ir, e_y, e_hi, e_lo;
    logic inc_pc, rd, e_alu;
    logic [5:0]  opc;
    logic [15:0] s_r;
    logic [15:0] e_r;
    logic        halted;
  } bundle_t;

  logic w_clock = 1'b0;
  logic w_clear, w_run, w_mem_rdy;
  logic w_step;
  logic [31:0] ir;
  logic s_PC, s_Zlow, s_Zhigh, s_MDR, s_HI, s_LO;
  logic e_MAR, e_Z, e_PC, e_MDR, e_IR, e_Y, e_HI, e_LO;
  logic w_IncPC, w_read, e_alu, halted;
  logic [5:0]  opcode;
  logic [15:0] s_R, e_R;

  int checks = 0;
  int errors = 0;
  bit checking = 0;
  bit idle_now = 1;
  bundle_t exp_q[$];
  bundle_t dut_log[$];
  bundle_t dut_b, cmp_exp;

  control_sequencer #(.NREGS(16), .OPW(6)) dut (
    .w_clock(w_clock), .w_clear(w_clear), .w_run(w_run), .w_mem_rdy(w_mem_rdy),
`ifdef CTRL_SINGLE_STEP_EN
    .w_step(w_step),
`endif
    .ir(ir),
    .s_PC(s_PC), .s_Zlow(s_Zlow), .s_Zhigh(s_Zhigh), .s_MDR(s_MDR),
    .s_HI(s_HI), .s_LO(s_LO),
    .e_MAR(e_MAR), .e_Z(e_Z), .e_PC(e_PC), .e_MDR(e_MDR), .e_IR(e_IR),
    .e_Y(e_Y), .e_HI(e_HI), .e_LO(e_LO),
    .w_IncPC(w_IncPC), .w_read(w_read), .e_alu(e_alu), .opcode(opcode),
    .s_R(s_R), .e_R(e_R), .halted(halted)
  );

  always #5 w_clock = ~w_clock;

  always_comb begin
    dut_b = '0;
    dut_b.s_pc = s_PC;   dut_b.s_zlow = s_Zlow; dut_b.s_zhigh = s_Zhigh;
    dut_b.s_mdr = s_MDR; dut_b.s_hi = s_HI;     dut_b.s_lo = s_LO;
    dut_b.e_mar = e_MAR; dut_b.e_z = e_Z;       dut_b.e_pc = e_PC;
    dut_b.e_mdr = e_MDR; dut_b.e_ir = e_IR;     dut_b.e_y = e_Y;
    dut_b.e_hi = e_HI;   dut_b.e_lo = e_LO;     dut_b.inc_pc = w_IncPC;
    dut_b.rd = w_read;   dut_b.e_alu = e_alu;   dut_b.opc = opcode;
    dut_b.s_r = s_R;     dut_b.e_r = e_R;       dut_b.halted = halted;
  end

  // Per-cycle comparison against the model; an empty queue means idle (all zero).
  always @(negedge w_clock) begin
    if (checking) begin
      dut_log.push_back(dut_b);
      if (exp_q.size() > 0) cmp_exp = exp_q.pop_front();
      else                  cmp_exp = '0;
      checks++;
      if (dut_b !== cmp_exp) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t: got %h expected %h", $time, dut_b, cmp_exp);
      end
    end
  end

  task automatic check_lit(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Instruction-level model: the ordered list of control bundles one instruction produces.
  task automatic build_expect(input logic [31:0] instr, input int waits, input int halt_cycles);
    bundle_t b;
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    op = instr[31:27]; ra = instr[26:23]; rb = instr[22:19]; rc = instr[18:15];
    b = '0; b.s_pc = 1; b.e_mar = 1; b.inc_pc = 1; b.e_z = 1; exp_q.push_back(b);
    for (int i = 0; i <= waits; i++) begin
      b = '0; b.s_zlow = 1; b.rd = 1; b.e_mdr = 1; b.e_pc = (i == 0);
      exp_q.push_back(b);
    end
    b = '0; b.s_mdr = 1; b.e_ir = 1; exp_q.push_back(b);
    if (op == 5'd31) begin
      exp_q.push_back('0);
      for (int i = 0; i < halt_cycles; i++) begin
        b = '0; b.halted = 1; exp_q.push_back(b);
      end
    end else if (op > 5'd12) begin
      exp_q.push_back('0);
    end else begin
      b = '0; b.s_r = 16'h1 << rb; b.e_y = 1; exp_q.push_back(b);
      b = '0; b.s_r = 16'h1 << ((op == 5'd4 || op == 5'd12) ? rb : rc);
      b.e_alu = 1; b.e_z = 1; b.opc = {1'b0, op}; exp_q.push_back(b);
      b = '0; b.s_zlow = 1;
      if (op == 5'd5 || op == 5'd6) begin
        b.e_lo = 1; exp_q.push_back(b);
        b = '0; b.s_zhigh = 1; b.e_hi = 1; exp_q.push_back(b);
      end else begin
        b.e_r = 16'h1 << ra; exp_q.push_back(b);
      end
    end
  endtask

  task automatic start_go();
`ifdef CTRL_SINGLE_STEP_EN
    w_step = 1'b1;
`else
    w_run = 1'b1;
`endif
  endtask

  // Called half a cycle before the instruction's T0 (in IDLE or the previous
  // instruction's last cycle); returns half a cycle before the next T0.
  task automatic run_instr(input logic [31:0] instr, input int waits, input bit to_idle_in,
                           input int halt_cycles);
    int guard;
    bit to_idle;
`ifdef CTRL_SINGLE_STEP_EN
    to_idle = 1'b1;
`else
    to_idle = to_idle_in;
`endif
    dut_log.delete();
    ir = instr;
    build_expect(instr, waits, halt_cycles);
    w_mem_rdy = (waits == 0);
    if (idle_now) start_go();
    for (int c = 1; c <= 2 + waits; c++) begin
      @(negedge w_clock); #1;
      w_step = 1'b0;
`ifndef CTRL_SINGLE_STEP_EN
      if (to_idle) w_run = 1'b0;
`endif
    end
    w_mem_rdy = 1'b1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 50) begin
      @(negedge w_clock); #1;
      guard++;
      if (halt_cycles > 0) begin
        w_run  = guard[0];
        w_step = guard[1];
      end
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    if (to_idle && halt_cycles == 0) begin
      @(negedge w_clock); #1;
    end
    idle_now = to_idle;
  endtask

  initial begin
    int g;
    int cnt_a, cnt_b;
    w_clear = 1'b0; w_mem_rdy = 1'b1; w_step = 1'b0; ir = 32'h00918000;
`ifdef CTRL_SINGLE_STEP_EN
    w_run = 1'b1;
`else
    w_run = 1'b0;
`endif
    repeat (3) @(negedge w_clock);
    #1 w_clear = 1'b1;
    @(negedge w_clock); #1;
    check_lit("reset_idle", 64'(dut_b), 64'h0);

    // Reset in the middle of T4.
    start_go();
    g = 0;
    do begin @(negedge w_clock); #1 w_step = 1'b0; g++; end while (!e_alu && g < 20);
    check_lit("reach_T4", 64'(e_alu), 64'h1);
    check_lit("t4_e_z", 64'(e_Z), 64'h1);
    #1 w_clear = 1'b0;
`ifndef CTRL_SINGLE_STEP_EN
    w_run = 1'b0;
`endif
    #1 check_lit("async_clear_T4", 64'(dut_b), 64'h0);
    @(negedge w_clock); #1 w_clear = 1'b1;
    @(negedge w_clock); #1 check_lit("idle_after_clear", 64'(dut_b), 64'h0);
    start_go();
    @(negedge w_clock); #1 w_step = 1'b0;
    check_lit("t0_fetch", 64'({s_PC, e_MAR, w_IncPC, e_Z, s_Zlow}), 64'h1E);

    // Reset while waiting in T1 drops w_read at once.
    w_mem_rdy = 1'b0;
    g = 0;
    while (!w_read && g < 20) begin @(negedge w_clock); #1; g++; end
    check_lit("reach_T1", 64'(w_read), 64'h1);
    #1 w_clear = 1'b0;
`ifndef CTRL_SINGLE_STEP_EN
    w_run = 1'b0;
`endif
    #1 check_lit("async_clear_T1", 64'({w_read, e_MDR}), 64'h0);
    @(negedge w_clock); #1 w_clear = 1'b1; w_mem_rdy = 1'b1;
    checking = 1'b1;
    idle_now = 1'b1;
    repeat (5) @(negedge w_clock);
    #1;

`ifdef CTRL_SINGLE_STEP_EN
    // and R1,R2,R3 under single step: one pulse, one instruction, back to IDLE.
    run_instr(32'h10918000, 0, 1'b1, 0);
    check_lit("step_and_len", 64'(dut_log.size()), 64'd7);
    check_lit("step_and_opc", 64'(dut_log[4].opc), 64'd2);
    check_lit("step_idle_after", 64'(dut_log[6]), 64'h0);
    repeat (4) @(negedge w_clock);
    #1;
`endif

    // add R1,R2,R3 with w_mem_rdy tied high.
    run_instr(32'h00918000, 0, 1'b0, 0);
    check_lit("add_len", 64'(dut_log.size()), 64'd6);
    check_lit("add_t3_sr", 64'({dut_log[3].s_r, 3'b0, dut_log[3].e_y}), 64'h00041);
    check_lit("add_t4_sr", 64'(dut_log[4].s_r), 64'h0008);
    check_lit("add_t4_alu", 64'({dut_log[4].opc, dut_log[4].e_alu, dut_log[4].e_z}), 64'h3);
    check_lit("add_t5_er", 64'({dut_log[5].e_r, 3'b0, dut_log[5].s_zlow}), 64'h00021);

    // sub R1,R2,R3 with three wait cycles in T1.
    run_instr(32'h08918000, 3, 1'b0, 0);
    cnt_a = 0; cnt_b = 0;
    foreach (dut_log[i]) begin
      cnt_a += int'(dut_log[i].rd);
      cnt_b += int'(dut_log[i].e_pc);
    end
    check_lit("wait_read_cycles", 64'(cnt_a), 64'd4);
    check_lit("wait_epc_cycles", 64'(cnt_b), 64'd1);
    check_lit("wait_epc_first", 64'(dut_log[1].e_pc), 64'h1);
    check_lit("wait_t2_after_rdy", 64'(dut_log[5].e_ir), 64'h1);

    // add R0,R2,R3: register 0 is still written.
    run_instr(32'h00118000, 0, 1'b0, 0);
    check_lit("ra0_er", 64'(dut_log[5].e_r), 64'h0001);

    // Illegal opcode 13 behaves as nop; w_run dropped mid-instruction.
    run_instr(32'h68000000, 0, 1'b1, 0);
    check_lit("illegal_len", 64'(dut_log.size()), 64'd5);

    // mul R4,R5 from IDLE.
    run_instr(32'h28228000, 0, 1'b0, 0);
    cnt_a = 0;
    foreach (dut_log[i]) cnt_a += (dut_log[i].e_r != 16'h0) ? 1 : 0;
    check_lit("mul_er_zero", 64'(cnt_a), 64'd0);
    check_lit("mul_t4_sr", 64'(dut_log[4].s_r), 64'h0020);
    check_lit("mul_t5_lo", 64'({dut_log[5].s_zlow, dut_log[5].e_lo}), 64'h3);
    check_lit("mul_t6_hi", 64'({dut_log[6].s_zhigh, dut_log[6].e_hi}), 64'h3);

    // neg R1,R2.
    run_instr(32'h60900000, 0, 1'b0, 0);
    check_lit("neg_t4_sr", 64'(dut_log[4].s_r), 64'h0004);
    check_lit("neg_t4_opc", 64'(dut_log[4].opc), 64'd12);
    check_lit("neg_t5_er", 64'(dut_log[5].e_r), 64'h0002);

    // halt, held 20 cycles while w_run toggles.
    run_instr(32'hF8000000, 0, 1'b0, 20);
    checking = 1'b0;
    cnt_a = 0;
    foreach (dut_log[i]) cnt_a += int'(dut_log[i].halted);
    check_lit("halt_cycles", 64'(cnt_a), 64'd20);
    check_lit("halt_still", 64'(halted), 64'h1);
    w_clear = 1'b0;
    #1 check_lit("halt_cleared", 64'(halted), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
